// File: rtl/prbs8_sequencer.sv
// -----------------------------------------------------------------------------
// prbs8_sequencer
//
// Purpose:
//   Command-driven controller for an 8-bit mask-programmable PRBS (LFSR)
//   generator. One command is accepted at a time. A stream command emits N
//   serial bits under valid/ready backpressure. A measure command steps the
//   LFSR until its state returns to the seed and reports that step count as
//   the period.
//
// Parameters:
//   LEN_W    width of cmd_len (bits per stream command)
//   TIMEOUT  max LFSR steps in measure mode before declaring no-return
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-low; clears all state on a clk edge
//   cmd_valid  in   command present
//   cmd_ready  out  high only in IDLE (and never while reset is low)
//   cmd_mode   in   0 = stream, 1 = measure period
//   cmd_mask   in   feedback tap mask
//   cmd_seed   in   initial LFSR state
//   cmd_len    in   bits to emit (stream mode only)
//   bit_valid  out  serial bit available (STREAM state)
//   bit_ready  in   consumer accepts bit
//   bit_data   out  current LFSR state bit 7
//   done       out  one-cycle pulse at the end of any command
//   err        out  qualified by done: seed==0, len==0, timeout or abort
//   period     out  measure result, held until next accepted command; 0 on error
//   abort      in   (only when PRBS8_SEQUENCER_ABORT_EN is defined) ends a
//                   running stream/measure command with err=1
//
// Configuration:
//   PRBS8_SEQUENCER_ABORT_EN  adds the abort input. Undefined by default.
//
// Handshakes (both interfaces): a transfer happens on a rising clk edge where
// valid and ready are both high. The producer holds valid and its payload
// stable until that edge; ready may change freely and valid never depends on
// ready.
// -----------------------------------------------------------------------------
module prbs8_sequencer #(
    parameter int LEN_W   = 16,
    parameter int TIMEOUT = 256
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_mode,
    input  logic [7:0]       cmd_mask,
    input  logic [7:0]       cmd_seed,
    input  logic [LEN_W-1:0] cmd_len,
    output logic             bit_valid,
    input  logic             bit_ready,
    output logic             bit_data,
    output logic             done,
    output logic             err,
    output logic [8:0]       period
`ifdef PRBS8_SEQUENCER_ABORT_EN
    ,
    input  logic             abort
`endif
);

    localparam logic [8:0]       TIMEOUT_C = 9'(TIMEOUT);
    localparam logic [LEN_W-1:0] LEN_ONE   = LEN_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_STREAM  = 2'd1,
        ST_MEASURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    state_t state, state_next;

    logic [7:0]       mask_q, mask_next;
    logic [7:0]       seed_q, seed_next;
    logic [7:0]       s_q, s_next;
    logic [LEN_W-1:0] rem_q, rem_next;
    logic [8:0]       cnt_q, cnt_next;
    logic             err_q, err_next;
    logic [8:0]       period_q, period_next;

    logic [7:0] s_step;
    logic [8:0] cnt_inc;
    logic       abort_req;

    // One LFSR step: shift left, feedback is the parity of the tapped bits.
    assign s_step  = {s_q[6:0], ^(s_q & mask_q)};
    assign cnt_inc = cnt_q + 9'd1;

`ifdef PRBS8_SEQUENCER_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= ST_IDLE;
            mask_q   <= '0;
            seed_q   <= '0;
            s_q      <= '0;
            rem_q    <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            period_q <= '0;
        end else begin
            state    <= state_next;
            mask_q   <= mask_next;
            seed_q   <= seed_next;
            s_q      <= s_next;
            rem_q    <= rem_next;
            cnt_q    <= cnt_next;
            err_q    <= err_next;
            period_q <= period_next;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_next  = state;
        mask_next   = mask_q;
        seed_next   = seed_q;
        s_next      = s_q;
        rem_next    = rem_q;
        cnt_next    = cnt_q;
        err_next    = err_q;
        period_next = period_q;

        case (state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    mask_next   = cmd_mask;
                    seed_next   = cmd_seed;
                    s_next      = cmd_seed;
                    rem_next    = cmd_len;
                    cnt_next    = '0;
                    period_next = '0;
                    err_next    = 1'b0;
                    // An all-zero seed locks the LFSR at zero, and a zero-length
                    // stream has nothing to emit: both finish immediately.
                    if (cmd_seed == 8'h00 || (!cmd_mode && cmd_len == '0)) begin
                        err_next   = 1'b1;
                        state_next = ST_DONE;
                    end else if (cmd_mode) begin
                        state_next = ST_MEASURE;
                    end else begin
                        state_next = ST_STREAM;
                    end
                end
            end

            ST_STREAM: begin
                if (abort_req) begin
                    err_next    = 1'b1;
                    period_next = '0;
                    state_next  = ST_DONE;
                end else if (bit_ready) begin
                    s_next   = s_step;
                    rem_next = rem_q - LEN_ONE;
                    if (rem_q == LEN_ONE) begin
                        state_next = ST_DONE;
                    end
                end
            end

            ST_MEASURE: begin
                if (abort_req) begin
                    err_next    = 1'b1;
                    period_next = '0;
                    state_next  = ST_DONE;
                end else begin
                    s_next   = s_step;
                    cnt_next = cnt_inc;
                    // cnt_inc is the index of the step being taken now, so a
                    // match reports it directly as the period.
                    if (s_step == seed_q) begin
                        period_next = cnt_inc;
                        err_next    = 1'b0;
                        state_next  = ST_DONE;
                    end else if (cnt_inc == TIMEOUT_C) begin
                        period_next = '0;
                        err_next    = 1'b1;
                        state_next  = ST_DONE;
                    end
                end
            end

            ST_DONE: begin
                state_next = ST_IDLE;
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Handshake/strobe outputs are forced low while reset is held so that a
    // requester never sees the block as ready before reset is released.
    assign cmd_ready = reset && (state == ST_IDLE);
    assign bit_valid = reset && (state == ST_STREAM);
    assign done      = reset && (state == ST_DONE);
    assign bit_data  = s_q[7];
    assign err       = err_q;
    assign period    = period_q;

endmodule

// File: tb/tb_prbs8_sequencer.sv
// -----------------------------------------------------------------------------
// tb_prbs8_sequencer
//
// Self-checking bench for prbs8_sequencer. Expected bits and periods come from
// an arithmetic reference model of the LFSR (multiply-by-two plus tap parity),
// run independently of the design.
// -----------------------------------------------------------------------------
module tb_prbs8_sequencer;

    localparam int LEN_W   = 16;
    localparam int TIMEOUT = 256;

    // ------------------------------------------------------------------ clock/reset
    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic             cmd_mode = 1'b0;
    logic [7:0]       cmd_mask = 8'h00;
    logic [7:0]       cmd_seed = 8'h00;
    logic [LEN_W-1:0] cmd_len = '0;
    logic             bit_valid;
    logic             bit_ready = 1'b0;
    logic             bit_data;
    logic             done;
    logic             err;
    logic [8:0]       period;
    logic             abort = 1'b0;

    always #5 clk = ~clk;

    prbs8_sequencer #(.LEN_W(LEN_W), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_mode  (cmd_mode),
        .cmd_mask  (cmd_mask),
        .cmd_seed  (cmd_seed),
        .cmd_len   (cmd_len),
        .bit_valid (bit_valid),
        .bit_ready (bit_ready),
        .bit_data  (bit_data),
        .done      (done),
        .err       (err),
        .period    (period)
`ifdef PRBS8_SEQUENCER_ABORT_EN
        ,
        .abort     (abort)
`endif
    );

    int n_cmp = 0;
    int n_err = 0;

    logic exp_q[$];
    logic got_q[$];

    // ------------------------------------------------------------------ reference model
    function automatic logic [7:0] model_next(input logic [7:0] s, input logic [7:0] m);
        int v;
        v = ((int'(s) * 2) % 256) + ($countones(s & m) % 2);
        return 8'(v);
    endfunction

    // Returns the period, or 0 when the seed is never revisited within TIMEOUT.
    function automatic int model_period(input logic [7:0] seed, input logic [7:0] m);
        logic [7:0] s;
        if (seed == 8'h00) return 0;
        s = seed;
        for (int c = 1; c <= TIMEOUT; c++) begin
            s = model_next(s, m);
            if (s == seed) return c;
        end
        return 0;
    endfunction

    function automatic void model_bits(input logic [7:0] seed, input logic [7:0] m, input int len);
        logic [7:0] s;
        s = seed;
        exp_q.delete();
        for (int i = 0; i < len; i++) begin
            exp_q.push_back(s[7]);
            s = model_next(s, m);
        end
    endfunction

    // ------------------------------------------------------------------ driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents a command and returns just after the accepting edge.
    task automatic send_cmd(input logic mode, input logic [7:0] m, input logic [7:0] sd,
                            input logic [LEN_W-1:0] len);
        int waited;
        cmd_valid = 1'b1;
        cmd_mode  = mode;
        cmd_mask  = m;
        cmd_seed  = sd;
        cmd_len   = len;
        waited    = 0;
        while (!cmd_ready && waited < 50) begin
            tick();
            waited++;
        end
        n_cmp++;
        if (cmd_ready !== 1'b1) begin
            n_err++;
            $display("FAIL cmd_accept_wait: cmd_ready=%b required 1 within 50 cycles", cmd_ready);
        end
        tick();
        cmd_valid = 1'b0;
    endtask

    // Runs a measure command to its done pulse; returns the observations.
    task automatic drive_measure(input logic [7:0] m, input logic [7:0] sd,
                                 output int edges, output logic err_o,
                                 output logic [8:0] per_o, output bit vseen,
                                 output bit timed_out);
        send_cmd(1'b1, m, sd, '0);
        edges = 0;
        vseen = 0;
        while (!done && edges < 400) begin
            if (bit_valid) vseen = 1;
            tick();
            edges++;
        end
        timed_out = !done;
        err_o     = err;
        per_o     = period;
        tick();
    endtask

    // Runs a stream command; ready_mode 0 = toggle 1,0,1,..., 1 = random, 2 = always.
    task automatic drive_stream(input logic [7:0] m, input logic [7:0] sd,
                                input logic [LEN_W-1:0] len, input int ready_mode,
                                output int edges, output int gaps, output int hold_viol,
                                output logic err_o, output logic vdone, output bit timed_out);
        bit   pending;
        logic prev_bit;
        logic r;
        int   k;
        send_cmd(1'b0, m, sd, len);
        got_q.delete();
        edges     = 0;
        gaps      = 0;
        hold_viol = 0;
        pending   = 0;
        prev_bit  = 1'b0;
        k         = 0;
        while (!done && edges < 2000) begin
            if (!bit_valid) gaps++;
            if (pending && bit_data !== prev_bit) hold_viol++;
            case (ready_mode)
                0:       r = (k % 2 == 0);
                1:       r = 1'($urandom_range(0, 1));
                default: r = 1'b1;
            endcase
            bit_ready = r;
            k++;
            if (bit_valid && r) got_q.push_back(bit_data);
            pending  = bit_valid && !r;
            prev_bit = bit_data;
            tick();
            edges++;
        end
        bit_ready = 1'b0;
        timed_out = !done;
        err_o     = err;
        vdone     = bit_valid;
        tick();
    endtask

    // ------------------------------------------------------------------ tests
    task automatic test_reset();
        reset = 1'b0;
        tick();
        n_cmp++;
        if (cmd_ready !== 1'b0) begin n_err++; $display("FAIL reset_cmd_ready_low: got %b required 0", cmd_ready); end
        tick();
        n_cmp++;
        if (done !== 1'b0) begin n_err++; $display("FAIL reset_done_low: got %b required 0", done); end
        reset = 1'b1;
        tick();
        n_cmp++;
        if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL reset_cmd_ready: got %b required 1", cmd_ready); end
        n_cmp++;
        if (bit_valid !== 1'b0) begin n_err++; $display("FAIL reset_bit_valid: got %b required 0", bit_valid); end
        n_cmp++;
        if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b required 0", done); end
        n_cmp++;
        if (period !== 9'd0) begin n_err++; $display("FAIL reset_period: got %0d required 0", period); end
        n_cmp++;
        if (err !== 1'b0 || bit_data !== 1'b0) begin
            n_err++; $display("FAIL reset_err_bit: got err=%b bit=%b required 0 0", err, bit_data);
        end
    endtask

    task automatic test_measure_fixed(input string name, input logic [7:0] m, input logic [7:0] sd,
                                      input int exp_edges, input logic exp_err,
                                      input logic [8:0] exp_per);
        int         edges;
        logic       e;
        logic [8:0] p;
        bit         vseen, to;
        drive_measure(m, sd, edges, e, p, vseen, to);
        n_cmp++;
        if (to || edges != exp_edges) begin
            n_err++; $display("FAIL %s_latency: got %0d edges (timeout=%0d) required %0d", name, edges, to, exp_edges);
        end
        n_cmp++;
        if (e !== exp_err) begin n_err++; $display("FAIL %s_err: got %b required %b", name, e, exp_err); end
        n_cmp++;
        if (p !== exp_per) begin n_err++; $display("FAIL %s_period: got %0d required %0d", name, p, exp_per); end
        n_cmp++;
        if (vseen) begin n_err++; $display("FAIL %s_bit_valid: got 1 during measure required 0", name); end
        n_cmp++;
        if (done !== 1'b0 || cmd_ready !== 1'b1) begin
            n_err++; $display("FAIL %s_single_done: got done=%b cmd_ready=%b required 0 1", name, done, cmd_ready);
        end
        tick();
        tick();
        n_cmp++;
        if (period !== exp_per) begin n_err++; $display("FAIL %s_period_hold: got %0d required %0d", name, period, exp_per); end
    endtask

    task automatic test_stream_toggle();
        int   edges, gaps, hv;
        logic e, vd;
        bit   to;
        model_bits(8'h81, 8'h80, 4);
        drive_stream(8'h80, 8'h81, 16'd4, 0, edges, gaps, hv, e, vd, to);
        n_cmp++;
        if (to || edges != 7) begin n_err++; $display("FAIL toggle_latency: got %0d edges (timeout=%0d) required 7", edges, to); end
        n_cmp++;
        if (got_q.size() != 4) begin n_err++; $display("FAIL toggle_count: got %0d bits required 4", got_q.size()); end
        foreach (got_q[i]) begin
            logic x;
            x = (exp_q.size() > 0) ? exp_q.pop_front() : 1'bx;
            n_cmp++;
            if (got_q[i] !== x) begin n_err++; $display("FAIL toggle_bit%0d: got %b required %b", i, got_q[i], x); end
        end
        n_cmp++;
        if (hv != 0 || gaps != 0) begin n_err++; $display("FAIL toggle_hold: got %0d hold changes %0d gaps required 0 0", hv, gaps); end
        n_cmp++;
        if (e !== 1'b0 || vd !== 1'b0) begin n_err++; $display("FAIL toggle_done: got err=%b bit_valid=%b required 0 0", e, vd); end
        n_cmp++;
        if (done !== 1'b0) begin n_err++; $display("FAIL toggle_single_done: got %b required 0", done); end
    endtask

    task automatic test_immediate_err(input string name, input logic mode, input logic [7:0] sd,
                                      input logic [LEN_W-1:0] len);
        send_cmd(mode, 8'hB8, sd, len);
        n_cmp++;
        if (done !== 1'b1 || err !== 1'b1) begin
            n_err++; $display("FAIL %s_done_err: got done=%b err=%b required 1 1", name, done, err);
        end
        n_cmp++;
        if (period !== 9'd0 || bit_valid !== 1'b0) begin
            n_err++; $display("FAIL %s_outputs: got period=%0d bit_valid=%b required 0 0", name, period, bit_valid);
        end
        tick();
        n_cmp++;
        if (done !== 1'b0 || cmd_ready !== 1'b1) begin
            n_err++; $display("FAIL %s_return_idle: got done=%b cmd_ready=%b required 0 1", name, done, cmd_ready);
        end
    endtask

    task automatic test_ignore_cmd();
        int cyc;
        model_bits(8'hC3, 8'hB8, 3);
        send_cmd(1'b0, 8'hB8, 8'hC3, 16'd3);
        bit_ready = 1'b0;
        tick();
        cmd_valid = 1'b1;
        cmd_mode  = 1'b1;
        cmd_mask  = 8'h80;
        cmd_seed  = 8'h01;
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (cmd_ready !== 1'b0 || bit_valid !== 1'b1 || done !== 1'b0) begin
                n_err++; $display("FAIL ignore_busy%0d: got ready=%b valid=%b done=%b required 0 1 0", i, cmd_ready, bit_valid, done);
            end
            tick();
        end
        cmd_valid = 1'b0;
        got_q.delete();
        cyc = 0;
        bit_ready = 1'b1;
        while (!done && cyc < 50) begin
            if (bit_valid) got_q.push_back(bit_data);
            tick();
            cyc++;
        end
        bit_ready = 1'b0;
        n_cmp++;
        if (!done || err !== 1'b0) begin n_err++; $display("FAIL ignore_done: got done=%b err=%b required 1 0", done, err); end
        foreach (got_q[i]) begin
            logic x;
            x = (exp_q.size() > 0) ? exp_q.pop_front() : 1'bx;
            n_cmp++;
            if (got_q[i] !== x) begin n_err++; $display("FAIL ignore_bit%0d: got %b required %b", i, got_q[i], x); end
        end
        n_cmp++;
        if (exp_q.size() != 0) begin n_err++; $display("FAIL ignore_missing: got %0d bits left required 0", exp_q.size()); end
        for (int i = 0; i < 4; i++) begin
            tick();
            n_cmp++;
            if (done !== 1'b0 || cmd_ready !== 1'b1) begin
                n_err++; $display("FAIL ignore_no_queue%0d: got done=%b ready=%b required 0 1", i, done, cmd_ready);
            end
        end
    endtask

    task automatic test_reset_mid_stream();
        send_cmd(1'b0, 8'hB8, 8'hFF, 16'd10);
        bit_ready = 1'b1;
        tick();
        tick();
        n_cmp++;
        if (bit_valid !== 1'b1 || bit_data !== 1'b1) begin
            n_err++; $display("FAIL midreset_pre: got valid=%b bit=%b required 1 1", bit_valid, bit_data);
        end
        reset = 1'b0;
        tick();
        n_cmp++;
        if (cmd_ready !== 1'b0 || bit_valid !== 1'b0 || bit_data !== 1'b0 || done !== 1'b0) begin
            n_err++; $display("FAIL midreset_outputs: got ready=%b valid=%b bit=%b done=%b required 0 0 0 0", cmd_ready, bit_valid, bit_data, done);
        end
        n_cmp++;
        if (err !== 1'b0 || period !== 9'd0) begin
            n_err++; $display("FAIL midreset_err_period: got err=%b period=%0d required 0 0", err, period);
        end
        bit_ready = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        n_cmp++;
        if (cmd_ready !== 1'b1 || done !== 1'b0) begin
            n_err++; $display("FAIL midreset_recover: got ready=%b done=%b required 1 0", cmd_ready, done);
        end
    endtask

    task automatic test_random_measure();
        for (int it = 0; it < 12; it++) begin
            logic [7:0] m, sd;
            int         ep, edges, exp_edges;
            logic       e;
            logic [8:0] p;
            bit         vseen, to;
            m  = 8'($urandom_range(0, 255));
            sd = (it == 5) ? 8'h00 : 8'($urandom_range(1, 255));
            ep = model_period(sd, m);
            exp_edges = (sd == 8'h00) ? 0 : ((ep != 0) ? ep : TIMEOUT);
            drive_measure(m, sd, edges, e, p, vseen, to);
            n_cmp++;
            if (to || edges != exp_edges) begin
                n_err++; $display("FAIL rmeas%0d_latency: got %0d edges required %0d (mask=%h seed=%h)", it, edges, exp_edges, m, sd);
            end
            n_cmp++;
            if (p !== 9'(ep) || e !== (ep == 0)) begin
                n_err++; $display("FAIL rmeas%0d_result: got period=%0d err=%b required %0d %b (mask=%h seed=%h)", it, p, e, ep, (ep == 0), m, sd);
            end
            n_cmp++;
            if (vseen) begin n_err++; $display("FAIL rmeas%0d_bit_valid: got 1 required 0", it); end
        end
    endtask

    task automatic test_random_stream();
        for (int it = 0; it < 8; it++) begin
            logic [7:0] m, sd;
            int         len, edges, gaps, hv, bad;
            logic       e, vd;
            bit         to;
            m   = 8'($urandom_range(0, 255));
            sd  = 8'($urandom_range(1, 255));
            len = $urandom_range(1, 24);
            model_bits(sd, m, len);
            drive_stream(m, sd, 16'(len), 1, edges, gaps, hv, e, vd, to);
            bad = 0;
            foreach (got_q[i]) begin
                logic x;
                x = (exp_q.size() > 0) ? exp_q.pop_front() : 1'bx;
                if (got_q[i] !== x) bad++;
            end
            n_cmp++;
            if (to || bad != 0 || exp_q.size() != 0) begin
                n_err++; $display("FAIL rstream%0d_bits: got %0d wrong %0d missing (timeout=%0d) required 0 0 (mask=%h seed=%h len=%0d)", it, bad, exp_q.size(), to, m, sd, len);
            end
            n_cmp++;
            if (hv != 0 || gaps != 0 || e !== 1'b0 || vd !== 1'b0) begin
                n_err++; $display("FAIL rstream%0d_flow: got hold=%0d gaps=%0d err=%b valid=%b required 0 0 0 0", it, hv, gaps, e, vd);
            end
        end
    endtask

`ifdef PRBS8_SEQUENCER_ABORT_EN
    task automatic test_abort();
        send_cmd(1'b1, 8'hB8, 8'h01, '0);
        tick();
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_cmp++;
        if (done !== 1'b1 || err !== 1'b1 || period !== 9'd0) begin
            n_err++; $display("FAIL abort_measure: got done=%b err=%b period=%0d required 1 1 0", done, err, period);
        end
        tick();
        abort = 1'b1;
        tick();
        n_cmp++;
        if (done !== 1'b0 || cmd_ready !== 1'b1) begin
            n_err++; $display("FAIL abort_idle_ignored: got done=%b ready=%b required 0 1", done, cmd_ready);
        end
        abort = 1'b0;
    endtask
`endif

    // ------------------------------------------------------------------ sequence + report
    initial begin
        test_reset();
        test_measure_fixed("meas_rot", 8'h80, 8'h01, 8, 1'b0, 9'd8);
        test_measure_fixed("meas_max", 8'hB8, 8'h01, 255, 1'b0, 9'd255);
        test_measure_fixed("meas_tmo", 8'h00, 8'h01, 256, 1'b1, 9'd0);
        test_stream_toggle();
        test_immediate_err("seed0_stream", 1'b0, 8'h00, 16'd4);
        test_immediate_err("seed0_measure", 1'b1, 8'h00, 16'd0);
        test_immediate_err("len0_stream", 1'b0, 8'h5A, 16'd0);
        test_ignore_cmd();
        test_reset_mid_stream();
        test_random_measure();
        test_random_stream();
`ifdef PRBS8_SEQUENCER_ABORT_EN
        test_abort();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
